// File: rtl/msb_decode.sv
// Rebuilds a W-bit word from a stream of MSB indices, one beat per cycle, and emits the word
// with its popcount and a sticky per-frame error flag when the last beat is accepted.
module msb_decode #(
    parameter int unsigned W  = 3,
    parameter int unsigned IW = 2,
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_idx,
    input  logic          in_zero,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_word,
    output logic [CW-1:0] out_cnt,
    output logic          out_err
);

    typedef enum logic {StFirst, StMid} state_e;

    state_e        state_q;
    logic [W-1:0]  acc_q;
    logic [IW-1:0] prev_q;
    logic          ferr_q;

    logic          first;
    logic          accept;
    logic [W-1:0]  nacc;
    logic [CW-1:0] ncnt;
    logic          beat_err;

    assign first    = (state_q == StFirst);
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        nacc     = acc_q;
        beat_err = 1'b0;
        if (in_zero) begin
            // An empty word is only legal as a complete single-beat frame.
            beat_err = !first || !in_last;
        end else if (32'(in_idx) >= W) begin
            beat_err = 1'b1;
        end else begin
            nacc     = acc_q | (W'(1) << in_idx);
            beat_err = !first && (in_idx >= prev_q);
        end

        ncnt = '0;
        for (int i = 0; i < int'(W); i++) begin
            ncnt = ncnt + CW'(nacc[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFirst;
            acc_q     <= '0;
            prev_q    <= '0;
            ferr_q    <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_cnt   <= '0;
            out_err   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                prev_q <= in_idx;
                if (in_last) begin
                    // A last beat accepted alongside a drain keeps out_valid high.
                    out_valid <= 1'b1;
                    out_word  <= nacc;
                    out_cnt   <= ncnt;
                    out_err   <= ferr_q | beat_err;
                    acc_q     <= '0;
                    ferr_q    <= 1'b0;
                    state_q   <= StFirst;
                end else begin
                    acc_q   <= nacc;
                    ferr_q  <= ferr_q | beat_err;
                    state_q <= StMid;
                end
            end
        end
    end

endmodule

// File: tb/tb_msb_decode.sv
// Directed bench for msb_decode (W=3): vector table with free-flowing output, plus
// hand-written backpressure and mid-frame reset sequences.
module tb_msb_decode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_idx;
    logic       in_zero;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_word;
    logic [1:0] out_cnt;
    logic       out_err;

    int total = 0;
    int bad   = 0;

    msb_decode #(.W(3), .IW(2), .CW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_zero   (in_zero),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_cnt   (out_cnt),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] idx;
        logic       zero;
        logic       last;
        logic       ev;
        logic [2:0] w;
        logic [1:0] c;
        logic       e;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] idx, input logic zero, input logic last);
        in_valid = 1'b1;
        in_idx   = idx;
        in_zero  = zero;
        in_last  = last;
    endtask

    initial begin
        //           idx   zero  last  ev    word    cnt   err
        vecs[0]  = '{2'd2, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0};
        vecs[1]  = '{2'd0, 1'b0, 1'b1, 1'b1, 3'b101, 2'd2, 1'b0};
        vecs[2]  = '{2'd0, 1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0};
        vecs[3]  = '{2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0};
        vecs[4]  = '{2'd0, 1'b1, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
        vecs[5]  = '{2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0};
        vecs[6]  = '{2'd1, 1'b0, 1'b1, 1'b1, 3'b011, 2'd2, 1'b1};
        vecs[7]  = '{2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0};
        vecs[8]  = '{2'd1, 1'b0, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
        vecs[9]  = '{2'd3, 1'b0, 1'b1, 1'b1, 3'b000, 2'd0, 1'b1};
        vecs[10] = '{2'd2, 1'b0, 1'b1, 1'b1, 3'b100, 2'd1, 1'b0};
        vecs[11] = '{2'd2, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0};
        vecs[12] = '{2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0};
        vecs[13] = '{2'd0, 1'b0, 1'b1, 1'b1, 3'b111, 2'd3, 1'b0};
        vecs[14] = '{2'd2, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0};
        vecs[15] = '{2'd3, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0};
        vecs[16] = '{2'd1, 1'b0, 1'b1, 1'b1, 3'b110, 2'd2, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_zero   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_word", 32'(out_word), 0);
        check("reset out_cnt", 32'(out_cnt), 0);
        check("reset out_err", 32'(out_err), 0);
        check("reset in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            beat(vecs[i].idx, vecs[i].zero, vecs[i].last);
            step();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 1);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d out_word", i), 32'(out_word), 32'(vecs[i].w));
                check($sformatf("vec%0d out_cnt", i), 32'(out_cnt), 32'(vecs[i].c));
                check($sformatf("vec%0d out_err", i), 32'(out_err), 32'(vecs[i].e));
            end
        end
        in_valid = 1'b0;
        step();
        check("drain out_valid", 32'(out_valid), 0);

        // Backpressure: word held, pending beat blocked, accepted the cycle ready rises.
        out_ready = 1'b0;
        beat(2'd2, 1'b0, 1'b1);
        step();
        beat(2'd1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 1);
            check($sformatf("bp%0d out_word", k), 32'(out_word), 32'(3'b100));
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("bp next out_valid", 32'(out_valid), 1);
        check("bp next out_word", 32'(out_word), 32'(3'b010));
        check("bp next out_err", 32'(out_err), 0);
        step();
        check("bp done out_valid", 32'(out_valid), 0);

        // Reset mid-frame discards the partial word.
        beat(2'd2, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-rst out_valid", 32'(out_valid), 0);
        check("mid-rst out_word", 32'(out_word), 0);
        check("mid-rst out_cnt", 32'(out_cnt), 0);
        check("mid-rst out_err", 32'(out_err), 0);
        check("mid-rst in_ready", 32'(in_ready), 1);
        #2;
        rst_n = 1'b1;
        beat(2'd0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        check("post-rst out_valid", 32'(out_valid), 1);
        check("post-rst out_word", 32'(out_word), 32'(3'b001));
        check("post-rst out_cnt", 32'(out_cnt), 1);
        check("post-rst out_err", 32'(out_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
